// File: rtl/fsm_input_debouncer.sv
// Two-channel switch debouncer feeding fsm_ex1_type1: each raw level is synchronized,
// filtered by a per-channel stability FSM, and presented as a registered level plus rise strobe.

module fsm_input_debouncer_ch #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    typedef enum logic [1:0] {
        S_LO     = 2'b00,
        S_LO_CHK = 2'b01,
        S_HI     = 2'b11,
        S_HI_CHK = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;

    // Two-flop synchronizer; only sync2_q is allowed to reach the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // State, counter and registered outputs advance together on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LO;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    // Next-state: any disagreement inside a CHK state falls back to the stable state.
    always_comb begin
        state_d = S_LO;
        cnt_d   = CNT_ZERO;
        case (state_q)
            S_LO: begin
                if (sync2_q) begin
                    state_d = S_LO_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = S_LO;
                    cnt_d   = CNT_ZERO;
                end
            end
            S_LO_CHK: begin
                if (!sync2_q) begin
                    state_d = S_LO;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HI;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = S_LO_CHK;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_HI: begin
                if (!sync2_q) begin
                    state_d = S_HI_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = S_HI;
                    cnt_d   = CNT_ZERO;
                end
            end
            S_HI_CHK: begin
                if (sync2_q) begin
                    state_d = S_HI;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LO;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = S_HI_CHK;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LO;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state so level/rise register on the transition edge.
    always_comb begin
        level_d = 1'b0;
        rise_d  = 1'b0;
        case (state_d)
            S_HI, S_HI_CHK: level_d = 1'b1;
            default:        level_d = 1'b0;
        endcase
        if ((state_q == S_LO_CHK) && (state_d == S_HI)) begin
            rise_d = 1'b1;
        end else begin
            rise_d = 1'b0;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

module fsm_input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic b_rise
);

    fsm_input_debouncer_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_a (
        .clk     (clk),
        .rst_n   (reset),
        .raw_i   (a_raw),
        .level_o (a),
        .rise_o  (a_rise)
    );

    fsm_input_debouncer_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_b (
        .clk     (clk),
        .rst_n   (reset),
        .raw_i   (b_raw),
        .level_o (b),
        .rise_o  (b_rise)
    );

endmodule
